// File: rtl/bus_device_port.sv
// Device-side bus endpoint: a TX FIFO served to the bus through pndng/pop/D_pop,
// and an RX FIFO that keeps only bus pushes addressed to this device or to broadcast.
module bus_device_port #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_valid,
    output logic [7:0]         drop_cnt,
    output logic [7:0]         misroute_cnt,
    output logic               proto_err
);

    localparam int             AW    = $clog2(depth);
    localparam int             CW    = AW + 1;
    localparam logic [CW-1:0]  FULL  = CW'(depth);

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [AW-1:0]      tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0]      tx_count, rx_count;

    logic       tx_do_pop, tx_do_wr, rx_do_rd, rx_do_wr;
    logic       rx_match, rx_drop, rx_misroute, bad_access;
    logic [7:0] dest;

    // A valid read in the same cycle frees a slot, so a write while full still lands.
    always_comb begin
        dest        = D_push[pckg_sz-1:pckg_sz-8];
        rx_match    = (dest == id) || (dest == broadcast);
        tx_do_pop   = pop && (tx_count != '0);
        tx_do_wr    = tx_wr && ((tx_count != FULL) || tx_do_pop);
        rx_do_rd    = rx_rd && (rx_count != '0);
        rx_do_wr    = push && rx_match && ((rx_count != FULL) || rx_do_rd);
        rx_drop     = push && rx_match && (rx_count == FULL) && !rx_do_rd;
        rx_misroute = push && !rx_match;
        bad_access  = (pop && (tx_count == '0)) || (rx_rd && (rx_count == '0));
    end

    assign pndng    = (tx_count != '0);
    assign tx_full  = (tx_count == FULL);
    assign D_pop    = pndng ? tx_mem[tx_rptr] : '0;
    assign rx_valid = (rx_count != '0);
    assign rx_data  = rx_valid ? rx_mem[rx_rptr] : '0;

    // Storage carries no reset; only the pointers and counts define what is buffered.
    always_ff @(posedge clk) begin
        if (tx_do_wr) tx_mem[tx_wptr] <= tx_data;
        if (rx_do_wr) rx_mem[rx_wptr] <= D_push;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_do_wr)  tx_wptr <= tx_wptr + 1'b1;
            if (tx_do_pop) tx_rptr <= tx_rptr + 1'b1;
            case ({tx_do_wr, tx_do_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_do_wr) rx_wptr <= rx_wptr + 1'b1;
            if (rx_do_rd) rx_rptr <= rx_rptr + 1'b1;
            case ({rx_do_wr, rx_do_rd})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Diagnostic counters saturate rather than wrap so a flood stays visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt     <= '0;
            misroute_cnt <= '0;
            proto_err    <= 1'b0;
        end else begin
            if (rx_drop && drop_cnt != 8'hFF)         drop_cnt     <= drop_cnt + 8'd1;
            if (rx_misroute && misroute_cnt != 8'hFF) misroute_cnt <= misroute_cnt + 8'd1;
            if (bad_access)                           proto_err    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_device_port.sv
// Self-checking bench for bus_device_port: a queue-based reference model of both
// FIFOs and the diagnostic counters, compared after every clock edge.
module tb_bus_device_port;

    logic        clk = 1'b0;
    logic        reset, pndng, pop, push, tx_wr, tx_full, rx_rd, rx_valid, proto_err;
    logic [15:0] D_pop, D_push, tx_data, rx_data;
    logic [7:0]  drop_cnt, misroute_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] txq [$];
    logic [15:0] rxq [$];
    int          exp_drop, exp_mis;
    logic        exp_proto;

    bus_device_port #(.pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data),
        .tx_full(tx_full), .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
        .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".pndng"},    16'(pndng),    16'(txq.size() != 0));
        checkOutput({tag, ".tx_full"},  16'(tx_full),  16'(txq.size() == 8));
        checkOutput({tag, ".D_pop"},    D_pop,         (txq.size() != 0) ? txq[0] : 16'h0);
        checkOutput({tag, ".rx_valid"}, 16'(rx_valid), 16'(rxq.size() != 0));
        checkOutput({tag, ".rx_data"},  rx_data,       (rxq.size() != 0) ? rxq[0] : 16'h0);
        checkOutput({tag, ".drop"},     16'(drop_cnt), 16'(exp_drop));
        checkOutput({tag, ".misroute"}, 16'(misroute_cnt), 16'(exp_mis));
        checkOutput({tag, ".proto"},    16'(proto_err), 16'(exp_proto));
    endtask

    // Drive one cycle of stimulus and advance the reference model by the same edge.
    task automatic applyStimulus(input logic wr, input logic [15:0] wd, input logic p,
                                 input logic ps, input logic [15:0] pd, input logic rd);
        logic pop_ok, wr_ok, rd_ok, match;
        tx_wr = wr; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = rd;
        pop_ok = p && txq.size() > 0;
        wr_ok  = wr && (txq.size() < 8 || pop_ok);
        rd_ok  = rd && rxq.size() > 0;
        match  = (pd[15:8] == 8'h02) || (pd[15:8] == 8'hFF);
        if ((p && txq.size() == 0) || (rd && rxq.size() == 0)) exp_proto = 1'b1;
        @(posedge clk);
        #1;
        if (pop_ok) void'(txq.pop_front());
        if (wr_ok)  txq.push_back(wd);
        if (rd_ok)  void'(rxq.pop_front());
        if (ps) begin
            if (!match) begin
                if (exp_mis < 255) exp_mis++;
            end else if (rxq.size() < 8 || rd_ok) begin
                rxq.push_back(pd);
            end else if (exp_drop < 255) begin
                exp_drop++;
            end
        end
        tx_wr = 0; tx_data = 0; pop = 0; push = 0; D_push = 0; rx_rd = 0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        txq.delete(); rxq.delete();
        exp_drop = 0; exp_mis = 0; exp_proto = 1'b0;
    endtask

    initial begin
        reset = 0; pop = 0; push = 0; D_push = 0; tx_wr = 0; tx_data = 0; rx_rd = 0;
        doReset();
        checkAll("reset");

        // TX ordering through the show-ahead head
        applyStimulus(1, 16'h0201, 0, 0, 0, 0);
        checkOutput("tx_first_latency", D_pop, 16'h0201);
        applyStimulus(1, 16'h0302, 0, 0, 0, 0);
        applyStimulus(1, 16'hFF03, 0, 0, 0, 0);
        checkAll("tx3");
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("tx_pop1", D_pop, 16'h0302);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("tx_pop2", D_pop, 16'hFF03);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("tx_empty", 16'(pndng), 16'h0);
        checkAll("tx_drained");

        // TX full, overflow discard, write+pop while full
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 16'h1000 + 16'(i), 0, 0, 0, 0);
            if (i == 7) checkOutput("tx_full_at8", 16'(tx_full), 16'h1);
        end
        checkAll("tx_overflow");
        applyStimulus(1, 16'h10AA, 1, 0, 0, 0);
        checkOutput("tx_full_wrpop", 16'(tx_full), 16'h1);
        checkOutput("tx_head_wrpop", D_pop, 16'h1001);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
            checkAll("tx_drain");
        end

        // RX filtering
        applyStimulus(0, 0, 0, 1, 16'h0208, 0);
        checkOutput("rx_first", rx_data, 16'h0208);
        applyStimulus(0, 0, 0, 1, 16'hFF09, 0);
        applyStimulus(0, 0, 0, 1, 16'h050A, 0);
        checkOutput("misroute1", 16'(misroute_cnt), 16'h1);
        checkAll("rx_filter");
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("rx_second", rx_data, 16'hFF09);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkAll("rx_drained");

        // RX full drops, then read+push accepted
        for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0, 1, 16'h02A0 + 16'(i), 0);
        checkOutput("drop3", 16'(drop_cnt), 16'h3);
        checkAll("rx_full");
        applyStimulus(0, 0, 0, 1, 16'h02B0, 1);
        checkOutput("drop_stays3", 16'(drop_cnt), 16'h3);
        checkAll("rx_rdpush");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            checkAll("rx_drain");
        end

        // Protocol error, sticky, pointers untouched
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("proto_set", 16'(proto_err), 16'h1);
        applyStimulus(1, 16'h0555, 0, 0, 0, 0);
        checkOutput("proto_sticky", 16'(proto_err), 16'h1);
        checkAll("proto_ptr");
        applyStimulus(0, 0, 1, 0, 0, 0);
        doReset();
        checkOutput("proto_cleared", 16'(proto_err), 16'h0);

        // Misroute saturation
        for (int i = 0; i < 260; i++) applyStimulus(0, 0, 0, 1, 16'h0500, 0);
        checkOutput("misroute_sat", 16'(misroute_cnt), 16'd255);
        doReset();

        // Mixed concurrent traffic against the model
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 1)),
                          {($urandom_range(0, 2) == 0) ? 8'h02 : (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h07), 8'($urandom)},
                          1'($urandom_range(0, 2) == 0));
            checkAll("mixed");
        end

        // Reset mid-transfer discards buffered packets
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0C00 + 16'(i), 0, 1, 16'h0200 + 16'(i), 0);
        checkAll("pre_reset");
        doReset();
        checkAll("post_reset");
        applyStimulus(1, 16'h0107, 0, 0, 0, 0);
        checkOutput("after_reset_tx", D_pop, 16'h0107);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_device_port.md
# bus_device_port

Device-side endpoint of the `bs_gnrtr_n_rbtr` bus, one instance per device.
- TX direction: buffers packets written by the local device and serves them to the bus through the `pndng`/`pop`/`D_pop` pop interface.
- RX direction: accepts packets the bus delivers through `push`/`D_push`, filters them by destination ID and buffers them for the local device.
- Sits between each device and the bus, as the counterpart of the bus's per-device FIFO ports.

## Interface
Parameters:
- `pckg_sz`, 16: packet width; bits `[pckg_sz-1:pckg_sz-8]` are the destination ID, the rest is payload.
- `depth`, 8: entries per FIFO; power of 2, ≥2.
- `id`, 0: this device's 8-bit ID.
- `broadcast`, 8'hFF: broadcast destination ID.

Ports (clock and reset first):
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pndng` out 1: TX FIFO not empty (bus-facing).
- `D_pop` out `pckg_sz`: TX head packet, show-ahead.
- `pop` in 1: bus consumes the TX head.
- `push` in 1: bus delivers `D_push`.
- `D_push` in `pckg_sz`: delivered packet.
- `tx_wr` in 1: device writes `tx_data`.
- `tx_data` in `pckg_sz`: packet to send.
- `tx_full` out 1: TX FIFO full.
- `rx_rd` in 1: device consumes `rx_data`.
- `rx_data` out `pckg_sz`: RX head, show-ahead.
- `rx_valid` out 1: RX FIFO not empty.
- `drop_cnt` out 8: RX packets dropped because RX was full; saturates at 255.
- `misroute_cnt` out 8: pushes whose destination is neither `id` nor `broadcast`; saturates at 255.
- `proto_err` out 1: sticky; set by `pop` while `pndng`=0, or by `rx_rd` while `rx_valid`=0.

## Operation
- Both FIFOs are circular buffers with `$clog2(depth)`-bit read/write pointers and a `$clog2(depth)+1`-bit occupancy count. Pointers wrap from `depth-1` to 0.
- TX write:
  - `tx_wr` with `tx_full`=0 stores `tx_data`.
  - `tx_wr` with `tx_full`=1 is discarded silently (device-side overflow is the device's responsibility).
  - Exception: `tx_wr` and a valid `pop` in the same cycle while full both take effect; count is unchanged.
- TX pop:
  - `pop` with `pndng`=1 advances the read pointer.
  - `pop` with `pndng`=0 is ignored and sets `proto_err`.
- `tx_wr` and `pop` on an empty FIFO in the same cycle: the pop is a protocol error, the write is stored, and `pndng` rises next cycle.
- RX accept: on `push`, let `dest = D_push[pckg_sz-1:pckg_sz-8]`.
  - `dest == id` or `dest == broadcast`: store the full packet, including its header.
  - Any other `dest`: discard it and increment `misroute_cnt`.
  - Accepted while RX is full: discard it and increment `drop_cnt`.
  - Exception: if `rx_rd` is valid in the same cycle, the push is accepted.
- RX read: `rx_rd` with `rx_valid`=1 advances the read pointer. `rx_rd` with `rx_valid`=0 is ignored and sets `proto_err`.
- Reset effects: clears both FIFOs' pointers and counts, both counters and `proto_err`. Storage contents are don't-care. A reset asserted mid-transfer discards all buffered packets.
- Reset values of outputs: `pndng`=0, `tx_full`=0, `rx_valid`=0, `drop_cnt`=0, `misroute_cnt`=0, `proto_err`=0. `D_pop` and `rx_data` are X-tolerant while their valid flag is 0; the implementation drives 0.

## Timing
- `tx_wr` accepted at edge N → `pndng`=1 and `D_pop`=`tx_data` valid after edge N (one-cycle latency).
- `D_pop` is stable while `pndng`=1 and no `pop` occurs. The next entry appears the cycle after a `pop` edge.
- `tx_full`, `pndng`, `rx_valid` and both counters are registered; they update on the edge that changes the state. There is no combinational path from `pop` or `tx_wr` to these flags.
- `push` accepted at edge N → `rx_valid`=1 after edge N.
- Back-to-back throughput: one `pop` per cycle and one `push` per cycle are sustainable, simultaneously with device-side traffic.
- `reset` takes priority over every other input on the same edge.

## Test plan
- Reset, then 3 `tx_wr` with 16'h0201, 16'h0302, 16'hFF03 → `pndng`=1 next cycle with `D_pop`=16'h0201. Three consecutive `pop` cycles present 0302, then FF03, then `pndng`=0.
- `depth`=8: 9 `tx_wr` → `tx_full`=1 after the 8th write; the 9th is discarded. A simultaneous `tx_wr`+`pop` while full keeps `tx_full`=1 and the FIFO order remains intact.
- `id`=2: pushes 16'h0208, 16'hFF09, 16'h050A → `rx_valid`=1, `rx_data`=0208 then FF09. `misroute_cnt`=1.
- Fill RX with 8 packets, push 3 more with `id` destination → `drop_cnt`=3 and contents are unchanged. Then `rx_rd`+`push` in the same cycle → push accepted, `drop_cnt` stays 3.
- `pop` while `pndng`=0 → `proto_err`=1 and sticky; pointers unchanged; `reset` clears it.
- 4 packets buffered in each FIFO, then `reset` for 1 cycle → all flags and counters 0 the next cycle. A new `tx_wr` of 16'h0107 appears on `D_pop` one cycle later.
